// File: rtl/dmem_ctrl.sv
// Load/store controller with round-robin two-port arbitration in front of a word memory.
// Converts byte/half/word requests to word accesses (RMW for sub-word stores, extension for loads).
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DAT_WIDTH-1:0]  p0_wdata,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic                  p0_unsigned,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DAT_WIDTH-1:0]  p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DAT_WIDTH-1:0]  p1_wdata,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic                  p1_unsigned,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DAT_WIDTH-1:0]  p1_rdata,
  output logic                  p1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DAT_WIDTH-1:0]  mem_rdata
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DAT_WIDTH-1:0]  wdata;
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
  } req_t;

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;

  logic                  mem_read_d, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DAT_WIDTH-1:0]  mem_wdata_d;
  logic [1:0]            rvalid_d;
  logic [DAT_WIDTH-1:0]  rdata_d;
  logic                  err_d;

  req_t sel_req;
  logic sel_port;
  logic grant;
  logic sel_err;

  function automatic logic is_err(input logic [ADDR_WIDTH-1:0] addr, input logic [1:0] size);
    is_err = (size == 2'b11)
          || (size == SZ_H && addr[0])
          || (size == SZ_W && addr[1:0] != 2'b00)
          || (addr[ADDR_WIDTH-1:2] >= DEPTH_IDX);
  endfunction

  function automatic logic [DAT_WIDTH-1:0] load_ext(input logic [DAT_WIDTH-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    load_ext = uns ? DAT_WIDTH'(b) : {{(DAT_WIDTH-8){b[7]}}, b};
      SZ_H:    load_ext = uns ? DAT_WIDTH'(h) : {{(DAT_WIDTH-16){h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  // Only byte and half stores take the merge path; word stores bypass READ.
  function automatic logic [DAT_WIDTH-1:0] store_merge(input logic [DAT_WIDTH-1:0] word,
                                                       input logic [15:0] data,
                                                       input logic [1:0] off,
                                                       input logic [1:0] size);
    logic [DAT_WIDTH-1:0] w;
    w = word;
    if (size == SZ_B) w[{off, 3'b000} +: 8] = data[7:0];
    else              w[{off[1], 4'b0000} +: 16] = data;
    store_merge = w;
  endfunction

  // Round-robin pick: on contention the port not granted last wins.
  always_comb begin
    if (p0_req && p1_req) sel_port = ~last_q;
    else                  sel_port = p1_req;
    sel_req = sel_port ? {p1_addr, p1_wdata, p1_we, p1_size, p1_unsigned}
                       : {p0_addr, p0_wdata, p0_we, p0_size, p0_unsigned};
    sel_err = is_err(sel_req.addr, sel_req.size);
    grant   = rst_n && (state_q == S_IDLE) && (p0_req || p1_req);
  end

  assign p0_gnt = grant && !sel_port;
  assign p1_gnt = grant &&  sel_port;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rvalid_d    = 2'b00;
    rdata_d     = '0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          last_d  = sel_port;
          port_d  = sel_port;
          addr_d  = sel_req.addr;
          wdata_d = sel_req.wdata[15:0];
          we_d    = sel_req.we;
          size_d  = sel_req.size;
          uns_d   = sel_req.uns;
          if (sel_err) begin
            state_d            = S_RESP;
            err_d              = 1'b1;
            rvalid_d[sel_port] = 1'b1;
          end else if (sel_req.we && sel_req.size == SZ_W) begin
            state_d     = S_WRITE;
            mem_write_d = 1'b1;
            mem_addr_d  = ADDR_WIDTH'(sel_req.addr[ADDR_WIDTH-1:2]);
            mem_wdata_d = sel_req.wdata;
          end else begin
            state_d    = S_READ;
            mem_read_d = 1'b1;
            mem_addr_d = ADDR_WIDTH'(sel_req.addr[ADDR_WIDTH-1:2]);
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          state_d     = S_WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = ADDR_WIDTH'(addr_q[ADDR_WIDTH-1:2]);
          mem_wdata_d = store_merge(mem_rdata, wdata_q, addr_q[1:0], size_q);
        end else begin
          state_d          = S_RESP;
          rvalid_d[port_q] = 1'b1;
          rdata_d          = load_ext(mem_rdata, addr_q[1:0], size_q, uns_q);
        end
      end
      S_WRITE: begin
        state_d          = S_RESP;
        rvalid_d[port_q] = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      p1_err    <= 1'b0;
    end else begin
      last_q    <= last_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      p0_rvalid <= rvalid_d[0];
      p0_rdata  <= rvalid_d[0] ? rdata_d : '0;
      p0_err    <= rvalid_d[0] && err_d;
      p1_rvalid <= rvalid_d[1];
      p1_rdata  <= rvalid_d[1] ? rdata_d : '0;
      p1_err    <= rvalid_d[1] && err_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, arbitration and reset-abort
// sequences, then random traffic against a byte-addressed reference memory.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_unsigned, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [1:0]  p0_size;
  logic        p1_req, p1_we, p1_unsigned, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [1:0]  p1_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [31:0] mem [64];
  logic [7:0]  ref_bytes [256];
  int          checks = 0;
  int          failures = 0;
  int          mon_viol = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
    .p0_size(p0_size), .p0_unsigned(p0_unsigned), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_size(p1_size), .p1_unsigned(p1_unsigned), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Behavioural Data_Memory: combinational read, clocked write.
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
  end

  // Cycle-level protocol invariants, reported once at the end.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if ((mem_read && mem_write) || (p0_gnt && p1_gnt) || (p0_rvalid && p1_rvalid)) mon_viol++;
      if ((mem_read || mem_write) && mem_addr >= 32'd64) mon_viol++;
      if (!mem_read && !mem_write && (mem_addr != 0 || mem_wdata != 0)) mon_viol++;
    end
  end

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic add(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    vec_t v;
    v.port = port; v.addr = addr; v.wdata = wdata; v.we = we; v.size = size; v.uns = uns;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  task automatic set_req(input int port, input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [1:0] sz, input logic u);
    if (port == 0) begin
      p0_req = v; p0_addr = a; p0_wdata = wd; p0_we = we; p0_size = sz; p0_unsigned = u;
    end else begin
      p1_req = v; p1_addr = a; p1_wdata = wd; p1_we = we; p1_size = sz; p1_unsigned = u;
    end
  endtask

  // Reference: memory as 256 bytes, little-endian, with the access rules in plain arithmetic.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic uns,
                        output logic [31:0] rd, output logic er, output int lat);
    int nb;
    logic [31:0] v;
    nb = 1 << size;
    er = (size == 2'b11) || ((addr % nb) != 0) || ((addr / 4) >= 64);
    rd = 32'h0;
    if (er) begin
      lat = 1;
    end else if (we) begin
      for (int b = 0; b < nb; b++) ref_bytes[int'(addr) + b] = wdata[8*b +: 8];
      lat = (nb == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int b = 0; b < nb; b++) v = v | (32'(ref_bytes[int'(addr) + b]) << (8*b));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
      rd = v;
      lat = 2;
    end
  endtask

  task automatic wait_gnt(input int port, output logic ok);
    int n;
    n = 0;
    #1;
    while (!(port == 0 ? p0_gnt : p1_gnt) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    ok = (port == 0) ? p0_gnt : p1_gnt;
  endtask

  // One transaction: lat counts cycles from grant to rvalid; first_mem is the first cycle with a memory strobe.
  task automatic run_op(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [1:0] size, input logic uns,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int first_mem, output int mem_acc);
    logic ok;
    rd = 32'h0; er = 1'b0; lat = -1; first_mem = -1; mem_acc = 0;
    @(negedge clk);
    set_req(port, 1'b1, addr, wdata, we, size, uns);
    wait_gnt(port, ok);
    if (!ok) begin
      chk("gnt_timeout", 32'h0, 32'h1);
      set_req(port, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      return;
    end
    @(negedge clk);
    set_req(port, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (mem_read || mem_write) begin
        mem_acc++;
        if (first_mem < 0) first_mem = c;
      end
      if (port == 0 ? p0_rvalid : p1_rvalid) begin
        rd = (port == 0) ? p0_rdata : p1_rdata;
        er = (port == 0) ? p0_err : p1_err;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("rvalid_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_op(input string tag, input logic [31:0] rd, input logic er, input int lat,
                          input int first_mem, input int mem_acc,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_err) chk({tag, "_mem_accesses"}, 32'(mem_acc), 32'h0);
    else         chk({tag, "_first_mem_cycle"}, 32'(first_mem), 32'h1);
  endtask

  function automatic int qget(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, elat, fm, acc, act, bad;
    int          g0[$], g1[$], rv0c[$], rv1c[$];
    logic [31:0] rv0d[$], rv1d[$];
    logic        ok;

    for (int i = 0; i < 64; i++) begin
      mem[i] <= 32'(i);
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = (b == 0) ? 8'(i) : 8'h00;
    end
    rst_n = 1'b0;
    set_req(0, 1'b1, 32'h14, 32'h0, 1'b0, 2'b10, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {24'h0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_read, mem_write}, 32'h0);
    chk("reset_data", p0_rdata | p1_rdata | mem_addr | mem_wdata, 32'h0);

    // Both ports request word loads continuously from the first cycle out of reset.
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'h00, 32'h0, 1'b0, 2'b10, 1'b0);
    set_req(1, 1'b1, 32'h04, 32'h0, 1'b0, 2'b10, 1'b0);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (p0_gnt) g0.push_back(c);
      if (p1_gnt) g1.push_back(c);
      if (p0_rvalid) begin rv0c.push_back(c); rv0d.push_back(p0_rdata); end
      if (p1_rvalid) begin rv1c.push_back(c); rv1d.push_back(p1_rdata); end
      @(negedge clk);
    end
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    chk("arb_p0_gnt_first", 32'(qget(g0, 0)), 32'd0);
    chk("arb_p1_gnt_first", 32'(qget(g1, 0)), 32'd3);
    chk("arb_p0_gnt_second", 32'(qget(g0, 1)), 32'd6);
    chk("arb_p1_gnt_second", 32'(qget(g1, 1)), 32'd9);
    chk("arb_p0_rvalid_cycle", 32'(qget(rv0c, 0)), 32'd2);
    chk("arb_p1_rvalid_cycle", 32'(qget(rv1c, 0)), 32'd5);
    chk("arb_p0_rdata", (rv0d.size() > 0) ? rv0d[0] : 32'hDEAD_DEAD, 32'h0);
    chk("arb_p1_rdata", (rv1d.size() > 0) ? rv1d[0] : 32'hDEAD_DEAD, 32'h1);

    // port, addr, wdata, we, size, uns, expected rdata, err, latency
    add(0, 32'h14, 32'h0,        1'b0, 2'b10, 1'b0, 32'h0000_0005, 1'b0, 2);
    add(0, 32'h15, 32'hAB,       1'b1, 2'b00, 1'b0, 32'h0,         1'b0, 3);
    add(0, 32'h15, 32'h0,        1'b0, 2'b00, 1'b0, 32'hFFFF_FFAB, 1'b0, 2);
    add(0, 32'h15, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_00AB, 1'b0, 2);
    add(1, 32'h1A, 32'h1234,     1'b1, 2'b01, 1'b0, 32'h0,         1'b0, 3);
    add(1, 32'h18, 32'h0,        1'b0, 2'b10, 1'b0, 32'h1234_0006, 1'b0, 2);
    add(0, 32'h13, 32'h0,        1'b0, 2'b01, 1'b0, 32'h0,         1'b1, 1);
    add(0, 32'h100, 32'h55,      1'b1, 2'b10, 1'b0, 32'h0,         1'b1, 1);
    add(1, 32'h00, 32'h0,        1'b0, 2'b11, 1'b0, 32'h0,         1'b1, 1);
    add(0, 32'h02, 32'h99,       1'b1, 2'b10, 1'b0, 32'h0,         1'b1, 1);
    add(1, 32'h21, 32'h77,       1'b1, 2'b01, 1'b0, 32'h0,         1'b1, 1);
    add(0, 32'h100, 32'h0,       1'b0, 2'b10, 1'b0, 32'h0,         1'b1, 1);
    add(0, 32'hFC, 32'h0,        1'b0, 2'b10, 1'b0, 32'h0000_003F, 1'b0, 2);
    add(1, 32'hFC, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 32'h0,         1'b0, 2);
    add(0, 32'hFE, 32'h0,        1'b0, 2'b01, 1'b0, 32'hFFFF_DEAD, 1'b0, 2);
    add(0, 32'hFC, 32'h0,        1'b0, 2'b01, 1'b1, 32'h0000_BEEF, 1'b0, 2);
    add(1, 32'hFD, 32'h0,        1'b0, 2'b00, 1'b0, 32'hFFFF_FFBE, 1'b0, 2);
    add(1, 32'hFF, 32'h0,        1'b0, 2'b00, 1'b1, 32'h0000_00DE, 1'b0, 2);
    add(0, 32'h14, 32'h0,        1'b0, 2'b01, 1'b0, 32'hFFFF_AB05, 1'b0, 2);
    add(0, 32'h1B, 32'h180,      1'b1, 2'b00, 1'b0, 32'h0,         1'b0, 3);
    add(0, 32'h18, 32'h0,        1'b0, 2'b10, 1'b0, 32'h8034_0006, 1'b0, 2);
    add(1, 32'hFE, 32'hFFFF7777, 1'b1, 2'b01, 1'b0, 32'h0,         1'b0, 3);
    add(1, 32'hFC, 32'h0,        1'b0, 2'b10, 1'b0, 32'h7777_BEEF, 1'b0, 2);

    foreach (vecs[i]) begin
      run_op(vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].uns,
             rd, er, lat, fm, acc);
      ref_op(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].uns, erd, eer, elat);
      check_op($sformatf("vec%0d", i), rd, er, lat, fm, acc, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Byte store aborted by reset while in READ: memory word 2 must stay intact.
    @(negedge clk);
    set_req(0, 1'b1, 32'h08, 32'h77, 1'b1, 2'b00, 1'b0);
    wait_gnt(0, ok);
    chk("abort_gnt", 32'(ok), 32'h1);
    @(negedge clk);
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    chk("abort_in_read", 32'(mem_read), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_reset_ctl", {24'h0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_read, mem_write}, 32'h0);
    chk("abort_reset_data", p0_rdata | p1_rdata | mem_addr | mem_wdata, 32'h0);
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_write || p0_rvalid || p1_rvalid) act++;
    end
    chk("abort_activity", 32'(act), 32'h0);
    rst_n = 1'b1;
    run_op(0, 32'h08, 32'h0, 1'b0, 2'b10, 1'b0, rd, er, lat, fm, acc);
    check_op("abort_reload", rd, er, lat, fm, acc, 32'h0000_0002, 1'b0, 2);

    for (int i = 0; i < 150; i++) begin
      int          port;
      logic [31:0] a, wd;
      logic        we, u;
      logic [1:0]  sz;
      port = int'($urandom_range(0, 1));
      a    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h11F));
      wd   = $urandom;
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      u    = 1'($urandom_range(0, 1));
      run_op(port, a, wd, we, sz, u, rd, er, lat, fm, acc);
      ref_op(we, sz, a, wd, u, erd, eer, elat);
      check_op($sformatf("rnd%0d", i), rd, er, lat, fm, acc, erd, eer, elat);
    end

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
      if (mem[i] !== w) bad++;
    end
    chk("final_memory_words_differing", 32'(bad), 32'h0);
    chk("protocol_violations", 32'(mon_viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
